imem_loader: RTL and testbench

- Upstream of the fetch stage. Accepts a byte stream of Y86-64 program image over a valid/ready handshake and writes it into the byte-addressed instruction memory through a registered write port.
- Releases the SEQ core by asserting proc_run with the entry PC.
- Parks the core again when the core reports halt, or when the image overflows memory.
- Tracks byte count and XOR checksum of the loaded image.

---
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams a Y86-64 program image into byte-addressed instruction memory, then
// releases the core at ENTRY_PC and parks it again on halt or image overflow.
module imem_loader #(
  parameter int          ADDR_W   = 10,
  parameter logic [63:0] ENTRY_PC = 64'd32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  input  logic              hlt,
  output logic              proc_run,
  output logic [63:0]       entry_pc,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   byte_count,
  output logic [7:0]        checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALTED,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic                s_ready_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [7:0]          imem_wdata_q;
  logic                proc_run_q;
  logic [63:0]         entry_pc_q;
  logic                busy_q;
  logic                err_q;
  logic [ADDR_W:0]     byte_count_q;
  logic [7:0]          checksum_q;
  logic                accept_d;

  // s_ready_q is high exactly while in LOAD, so it alone qualifies acceptance.
  assign accept_d = s_valid && s_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      proc_run_q   <= 1'b0;
      entry_pc_q   <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_count_q <= '0;
      checksum_q   <= '0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALTED, S_ERR: begin
          if (start) begin
            state_q      <= S_LOAD;
            s_ready_q    <= 1'b1;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
            wr_ptr_q     <= base_addr;
            byte_count_q <= '0;
            checksum_q   <= '0;
          end
        end
        S_LOAD: begin
          if (accept_d) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= wr_ptr_q;
            imem_wdata_q <= s_data;
            byte_count_q <= byte_count_q + CNT_ONE;
            checksum_q   <= checksum_q ^ s_data;
            if (wr_ptr_q != TOP_ADDR) begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (s_last) begin
              state_q    <= S_RUN;
              s_ready_q  <= 1'b0;
              busy_q     <= 1'b0;
              entry_pc_q <= ENTRY_PC;
            end else if (wr_ptr_q == TOP_ADDR) begin
              state_q   <= S_ERR;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b0;
              err_q     <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // proc_run lags entry into RUN by one cycle so the final write lands first.
          if (hlt) begin
            state_q    <= S_HALTED;
            proc_run_q <= 1'b0;
          end else begin
            proc_run_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign proc_run   = proc_run_q;
  assign entry_pc   = entry_pc_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign byte_count = byte_count_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads, hand-written timing
// sequences, and random loads checked against an arithmetic image model.
module tb_imem_loader;

  logic        clk, rst_n, start, s_valid, s_last, hlt;
  logic [9:0]  base_addr;
  logic [3:0]  base_addr4;
  logic [7:0]  s_data;

  logic        s_ready, imem_we, proc_run, busy, err;
  logic [9:0]  imem_addr;
  logic [7:0]  imem_wdata, checksum;
  logic [63:0] entry_pc;
  logic [10:0] byte_count;

  logic        s_ready4, imem_we4, proc_run4, busy4, err4;
  logic [3:0]  imem_addr4;
  logic [7:0]  imem_wdata4, checksum4;
  logic [63:0] entry_pc4;
  logic [4:0]  byte_count4;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [17:0] wr_q[$];

  imem_loader #(.ADDR_W(10), .ENTRY_PC(64'd32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .hlt(hlt), .proc_run(proc_run), .entry_pc(entry_pc), .busy(busy),
    .err(err), .byte_count(byte_count), .checksum(checksum)
  );

  imem_loader #(.ADDR_W(4), .ENTRY_PC(64'd32)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr4),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready4),
    .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
    .hlt(hlt), .proc_run(proc_run4), .entry_pc(entry_pc4), .busy(busy4),
    .err(err4), .byte_count(byte_count4), .checksum(checksum4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: each one-cycle imem_we pulse is seen at exactly one negedge.
  always @(negedge clk) begin
    if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0]  base;
    int          n;
    logic [31:0] bytes;
    bit          gaps;
    int          exp_cnt;
    logic [7:0]  exp_csum;
    bit          exp_run;
    bit          exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, output bit ok);
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int k = 0; k < 4 && !ok; k++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_load(input logic [9:0] base, input logic [7:0] d[$], input bit gaps);
    bit ok;
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    start = 1'b1;
    base_addr = base;
    base_addr4 = base[3:0];
    tick();
    start = 1'b0;
    wr_q.delete();
    for (int i = 0; i < d.size(); i++) begin
      send_byte(d[i], (i == d.size() - 1), ok);
      if (!ok) break;
      if (gaps) tick();
    end
    repeat (3) tick();
  endtask

  // Reference: the image fits if every byte lands at or below the top address;
  // otherwise only the bytes up to the top are written and the load errors out.
  function automatic void model(input int base, input logic [7:0] d[$],
                                output int cnt, output logic [7:0] cs, output bit ovf);
    int space;
    space = 1024 - base;
    ovf = d.size() > space;
    cnt = ovf ? space : d.size();
    cs = 8'h00;
    for (int i = 0; i < cnt; i++) cs ^= d[i];
  endfunction

  task automatic check_writes(input string tag, input int base, input logic [7:0] d[$], input int cnt);
    int bad;
    bad = 0;
    chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'(cnt));
    for (int i = 0; i < cnt && i < wr_q.size(); i++) begin
      if (wr_q[i] !== {10'(base + i), d[i]}) bad++;
    end
    chk({tag, "_wrdata"}, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [7:0] d[$];
    bit ok;
    int cnt;
    logic [7:0] cs;
    bit ovf;

    tbl[0] = '{10'd32,   3, 32'h0000F430, 1'b0, 3, 8'hC4, 1'b1, 1'b0};
    tbl[1] = '{10'd32,   3, 32'h0000F430, 1'b1, 3, 8'hC4, 1'b1, 1'b0};
    tbl[2] = '{10'd100,  1, 32'h00000010, 1'b0, 1, 8'h10, 1'b1, 1'b0};
    tbl[3] = '{10'd1022, 2, 32'h000055AA, 1'b0, 2, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{10'd1022, 3, 32'h00040201, 1'b1, 2, 8'h03, 1'b0, 1'b1};
    tbl[5] = '{10'd1023, 4, 32'h10204080, 1'b0, 1, 8'h80, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; hlt = 1'b0;
    base_addr = '0; base_addr4 = '0; s_data = '0;
    #12;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_proc_run", 64'(proc_run), 64'd0);
    chk("rst_busy_err", 64'({busy, err, imem_we}), 64'd0);
    chk("rst_count_csum", 64'({byte_count, checksum}), 64'd0);
    chk("rst_entry_pc", entry_pc, 64'd0);
    #5 rst_n = 1'b1;
    tick();

    // First image with exact write timing
    start = 1'b1; base_addr = 10'd32; base_addr4 = 4'd0;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("ld_busy", 64'({busy, s_ready}), 64'b11);
    tick();
    s_valid = 1'b1; s_data = 8'h30; s_last = 1'b0;
    tick();
    s_data = 8'hF4;
    @(negedge clk);
    chk("ld_wr0", 64'({imem_we, imem_addr, imem_wdata}), 64'({1'b1, 10'd32, 8'h30}));
    tick();
    s_data = 8'h00; s_last = 1'b1;
    @(negedge clk);
    chk("ld_wr1", 64'({imem_we, imem_addr, imem_wdata}), 64'({1'b1, 10'd33, 8'hF4}));
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("ld_wr2", 64'({imem_we, imem_addr, imem_wdata}), 64'({1'b1, 10'd34, 8'h00}));
    chk("ld_rdy_drop_run_low", 64'({s_ready, proc_run}), 64'b00);
    tick();
    @(negedge clk);
    chk("ld_run_nowrite", 64'({proc_run, imem_we}), 64'b10);
    chk("ld_entry_pc", entry_pc, 64'd32);
    chk("ld_count", 64'(byte_count), 64'd3);
    chk("ld_csum", 64'(checksum), 64'hC4);
    $display("load base=32 n=3 count=%0d csum=%02h run=%0b", byte_count, checksum, proc_run);

    // start and s_valid are ignored while running
    wr_q.delete();
    start = 1'b1; s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
    repeat (3) tick();
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("run_ign_writes", 64'(wr_q.size()), 64'd0);
    chk("run_ign_state", 64'({proc_run, busy, s_ready}), 64'b100);
    chk("run_ign_count", 64'(byte_count), 64'd3);
    $display("run ignore start/s_valid proc_run=%0b", proc_run);

    // Halt parks the core on the next edge
    tick();
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    @(negedge clk);
    chk("hlt_proc_run", 64'(proc_run), 64'd0);
    chk("hlt_entry_hold", entry_pc, 64'd32);
    $display("halt proc_run=%0b", proc_run);

    for (int i = 0; i < 6; i++) begin
      d.delete();
      for (int j = 0; j < tbl[i].n; j++) d.push_back(tbl[i].bytes[8*j +: 8]);
      do_load(tbl[i].base, d, tbl[i].gaps);
      @(negedge clk);
      $display("tbl%0d base=%0d n=%0d count=%0d csum=%02h run=%0b err=%0b",
               i, tbl[i].base, tbl[i].n, byte_count, checksum, proc_run, err);
      chk($sformatf("tbl%0d_count", i), 64'(byte_count), 64'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_csum", i), 64'(checksum), 64'(tbl[i].exp_csum));
      chk($sformatf("tbl%0d_run_err", i), 64'({proc_run, err}), 64'({tbl[i].exp_run, tbl[i].exp_err}));
      if (tbl[i].exp_err) chk($sformatf("tbl%0d_rdy", i), 64'(s_ready), 64'd0);
      check_writes($sformatf("tbl%0d", i), int'(tbl[i].base), d, tbl[i].exp_cnt);
    end

    for (int r = 0; r < 24; r++) begin
      int base, n;
      bit gaps;
      base = ($urandom_range(0, 3) == 0) ? 1024 - int'($urandom_range(1, 6)) : int'($urandom_range(0, 1000));
      n = $urandom_range(1, 8);
      gaps = 1'($urandom_range(0, 1));
      d.delete();
      for (int j = 0; j < n; j++) d.push_back(8'($urandom));
      do_load(10'(base), d, gaps);
      model(base, d, cnt, cs, ovf);
      @(negedge clk);
      $display("rnd%0d base=%0d n=%0d gaps=%0b count=%0d csum=%02h run=%0b err=%0b",
               r, base, n, gaps, byte_count, checksum, proc_run, err);
      chk($sformatf("rnd%0d_count", r), 64'(byte_count), 64'(cnt));
      chk($sformatf("rnd%0d_csum", r), 64'(checksum), 64'(cs));
      chk($sformatf("rnd%0d_run_err", r), 64'({proc_run, err}), 64'({!ovf, ovf}));
      check_writes($sformatf("rnd%0d", r), base, d, cnt);
    end

    // Asynchronous reset in the middle of a load
    hlt = 1'b1; tick(); hlt = 1'b0;
    start = 1'b1; base_addr = 10'd200; tick(); start = 1'b0;
    send_byte(8'h5A, 1'b0, ok);
    send_byte(8'hA5, 1'b0, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we_rdy_busy", 64'({imem_we, s_ready, busy, proc_run, err}), 64'd0);
    chk("arst_count_csum", 64'({byte_count, checksum}), 64'd0);
    chk("arst_entry_pc", entry_pc, 64'd0);
    #4 rst_n = 1'b1;
    tick();
    start = 1'b1; base_addr = 10'd300; tick(); start = 1'b0;
    @(negedge clk);
    chk("arst_fresh_load", 64'({busy, byte_count}), 64'({1'b1, 11'd0}));
    $display("async reset mid-load, fresh load count=%0d", byte_count);

    // Overflow on the 16-byte instance
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    tick();
    start = 1'b1; base_addr = 10'd14; base_addr4 = 4'd14; tick(); start = 1'b0;
    s_valid = 1'b1; s_last = 1'b0; s_data = 8'hA1;
    tick();
    s_data = 8'hB2;
    @(negedge clk);
    chk("ovf_wr14", 64'({imem_we4, imem_addr4, imem_wdata4}), 64'({1'b1, 4'd14, 8'hA1}));
    tick();
    s_data = 8'hC3;
    @(negedge clk);
    chk("ovf_wr15", 64'({imem_we4, imem_addr4, imem_wdata4}), 64'({1'b1, 4'd15, 8'hB2}));
    chk("ovf_err_rdy", 64'({err4, s_ready4, busy4}), 64'b100);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("ovf_third_rejected", 64'(imem_we4), 64'd0);
    chk("ovf_count_csum", 64'({byte_count4, checksum4}), 64'({5'd2, 8'h13}));
    chk("ovf_no_run", 64'(proc_run4), 64'd0);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("ovf_recover", 64'({err4, s_ready4, busy4, byte_count4}), 64'({3'b011, 5'd0}));
    $display("overflow ADDR_W=4 recovered err=%0b busy=%0b", err4, busy4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
